// File: rtl/vme_slave_responder.sv
// A24 VME slave cycle responder: decodes matching cycles, runs a local handshake
// and answers with DTACK, or with BERR when the local side does not respond in time.
module vme_slave_responder #(
    parameter int         TIMEOUT  = 15,
    parameter logic [5:0] AM_USER  = 6'h39,
    parameter logic [5:0] AM_SUPER = 6'h3D
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vme_as,
    input  logic [1:0] vme_ds,
    input  logic       vme_write,
    input  logic       vme_lword,
    input  logic [5:0] vme_address_mod,
    input  logic [7:0] vme_address_high,
    input  logic [7:0] base_address,
    output logic       vme_dtack,
    output logic       vme_berr,
    output logic       local_request,
    output logic       local_write,
    output logic [1:0] local_ds,
    output logic       local_lword,
    input  logic       local_ack
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACCESS  = 3'd1;
    localparam logic [2:0] ACK     = 3'd2;
    localparam logic [2:0] ERROR   = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;
    localparam logic [2:0] IGNORE  = 3'd5;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             latch_en;

    logic       as_p0, as_p1;
    logic [1:0] ds_p0, ds_p1;
    logic       ack_p0, ack_p1;

    logic       lat_write, lat_lword;
    logic [1:0] lat_ds;

    logic strobe, match, req_active;

    // two-flop synchronizers, idling at the inactive (high) level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            as_p0  <= 1'b1;
            as_p1  <= 1'b1;
            ds_p0  <= 2'b11;
            ds_p1  <= 2'b11;
            ack_p0 <= 1'b1;
            ack_p1 <= 1'b1;
        end else begin
            as_p0  <= vme_as;
            as_p1  <= as_p0;
            ds_p0  <= vme_ds;
            ds_p1  <= ds_p0;
            ack_p0 <= local_ack;
            ack_p1 <= ack_p0;
        end
    end

    assign strobe = !as_p1 && (ds_p1 != 2'b11);
    assign match  = strobe
                  && ((vme_address_mod == AM_USER) || (vme_address_mod == AM_SUPER))
                  && (vme_address_high == base_address);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                // RELEASE with AS still low decodes a new address-pipelined DS like IDLE
                if (state == RELEASE && as_p1) begin
                    state_nxt = IDLE;
                end else if (match) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                    latch_en  = 1'b1;
                end else if (strobe) begin
                    state_nxt = IGNORE;
                end
            end
            ACCESS: begin
                if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
                if (as_p1)              state_nxt = IDLE;
                else if (!ack_p1)       state_nxt = ACK;
                else if (cnt == CNT_MAX) state_nxt = ERROR;
            end
            ACK, ERROR: begin
                if (as_p1)                state_nxt = IDLE;
                else if (ds_p1 == 2'b11)  state_nxt = RELEASE;
            end
            IGNORE: begin
                if (as_p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b1;
            lat_ds    <= 2'b11;
            lat_lword <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_en) begin
                lat_write <= vme_write;
                lat_ds    <= vme_ds;
                lat_lword <= vme_lword;
            end
        end
    end

    // outputs decode straight from state so each handshake costs no extra clock
    assign req_active    = (state == ACCESS) || (state == ACK);
    assign local_request = !req_active;
    assign local_write   = req_active ? lat_write : 1'b1;
    assign local_ds      = req_active ? lat_ds    : 2'b11;
    assign local_lword   = req_active ? lat_lword : 1'b1;

    assign vme_dtack = (state == ACK)   ? 1'b0 : 1'bz;
    assign vme_berr  = (state == ERROR) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_vme_slave_responder.sv
// Directed bench for vme_slave_responder; bus lines are pulled up so a released
// DTACK/BERR reads as 1, exactly as on a real VME backplane.
module tb_vme_slave_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic       vme_as;
    logic [1:0] vme_ds;
    logic       vme_write;
    logic       vme_lword;
    logic [5:0] vme_address_mod;
    logic [7:0] vme_address_high;
    logic [7:0] base_address;
    wire        dtack_w;
    wire        berr_w;
    logic       local_request;
    logic       local_write;
    logic [1:0] local_ds;
    logic       local_lword;
    logic       local_ack;

    int checks = 0;
    int errors = 0;

    pullup (dtack_w);
    pullup (berr_w);

    vme_slave_responder #(
        .TIMEOUT  (15),
        .AM_USER  (6'h39),
        .AM_SUPER (6'h3D)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .vme_as           (vme_as),
        .vme_ds           (vme_ds),
        .vme_write        (vme_write),
        .vme_lword        (vme_lword),
        .vme_address_mod  (vme_address_mod),
        .vme_address_high (vme_address_high),
        .base_address     (base_address),
        .vme_dtack        (dtack_w),
        .vme_berr         (berr_w),
        .local_request    (local_request),
        .local_write      (local_write),
        .local_ds         (local_ds),
        .local_lword      (local_lword),
        .local_ack        (local_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_idle();
        vme_as = 1'b1;
        vme_ds = 2'b11;
        vme_write = 1'b1;
        vme_lword = 1'b1;
        local_ack = 1'b1;
    endtask

    task automatic start_cycle(input logic [5:0] am, input logic [7:0] addr,
                               input logic wr, input logic lw, input logic [1:0] ds);
        vme_address_mod  = am;
        vme_address_high = addr;
        vme_write        = wr;
        vme_lword        = lw;
        vme_as           = 1'b0;
        vme_ds           = ds;
    endtask

    initial begin
        reset = 1'b0;
        bus_idle();
        vme_address_mod  = 6'h00;
        vme_address_high = 8'h00;
        base_address     = 8'h20;
        #1;
        chk("reset_req",   {7'd0, local_request}, 8'h01);
        chk("reset_ds",    {6'd0, local_ds},      8'h03);
        chk("reset_write", {7'd0, local_write},   8'h01);
        chk("reset_lword", {7'd0, local_lword},   8'h01);
        chk("reset_dtack", {7'd0, dtack_w},       8'h01);
        chk("reset_berr",  {7'd0, berr_w},        8'h01);
        cyc(2);
        reset = 1'b1;
        cyc(2);

        // read, A24 user, longword, local ack two clocks after the request
        start_cycle(6'h39, 8'h20, 1'b1, 1'b0, 2'b00);
        cyc(2);
        chk("rd_req_lat2", {7'd0, local_request}, 8'h01);
        cyc(1);
        chk("rd_req_lat3", {7'd0, local_request}, 8'h00);
        chk("rd_ds",       {6'd0, local_ds},      8'h00);
        chk("rd_lword",    {7'd0, local_lword},   8'h00);
        chk("rd_write",    {7'd0, local_write},   8'h01);
        cyc(2);
        local_ack = 1'b0;
        cyc(2);
        chk("rd_dtack_lat2", {7'd0, dtack_w}, 8'h01);
        cyc(1);
        chk("rd_dtack_lat3", {7'd0, dtack_w},       8'h00);
        chk("rd_req_in_ack", {7'd0, local_request}, 8'h00);
        chk("rd_berr",       {7'd0, berr_w},        8'h01);
        cyc(1);
        chk("rd_dtack_hold", {7'd0, dtack_w}, 8'h00);
        vme_ds = 2'b11;
        local_ack = 1'b1;
        cyc(2);
        chk("rd_dtack_until_ds", {7'd0, dtack_w}, 8'h00);
        cyc(1);
        chk("rd_release_dtack", {7'd0, dtack_w},       8'h01);
        chk("rd_release_req",   {7'd0, local_request}, 8'h01);
        vme_as = 1'b1;
        cyc(4);

        // write with no local ack: BERR after the timeout, never DTACK
        start_cycle(6'h3D, 8'h20, 1'b0, 1'b1, 2'b10);
        cyc(3);
        chk("to_req",   {7'd0, local_request}, 8'h00);
        chk("to_write", {7'd0, local_write},   8'h00);
        chk("to_ds",    {6'd0, local_ds},      8'h02);
        chk("to_lword", {7'd0, local_lword},   8'h01);
        cyc(15);
        chk("to_berr_early", {7'd0, berr_w},        8'h01);
        chk("to_req_early",  {7'd0, local_request}, 8'h00);
        cyc(1);
        chk("to_berr",  {7'd0, berr_w},        8'h00);
        chk("to_dtack", {7'd0, dtack_w},       8'h01);
        chk("to_req_off", {7'd0, local_request}, 8'h01);
        cyc(3);
        chk("to_berr_hold",  {7'd0, berr_w},  8'h00);
        chk("to_dtack_hold", {7'd0, dtack_w}, 8'h01);
        vme_ds = 2'b11;
        cyc(3);
        chk("to_berr_release", {7'd0, berr_w}, 8'h01);
        vme_as = 1'b1;
        cyc(4);

        // non-matching address modifier, then non-matching address
        start_cycle(6'h29, 8'h20, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("nm_am_req",   {7'd0, local_request}, 8'h01);
            chk("nm_am_dtack", {7'd0, dtack_w},       8'h01);
            chk("nm_am_berr",  {7'd0, berr_w},        8'h01);
        end
        bus_idle();
        cyc(4);
        start_cycle(6'h39, 8'h21, 1'b1, 1'b0, 2'b00);
        local_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("nm_addr_req",   {7'd0, local_request}, 8'h01);
            chk("nm_addr_dtack", {7'd0, dtack_w},       8'h01);
            chk("nm_addr_berr",  {7'd0, berr_w},        8'h01);
        end
        bus_idle();
        cyc(4);

        // master abort: AS released while the local access is pending
        start_cycle(6'h39, 8'h20, 1'b1, 1'b0, 2'b00);
        cyc(3);
        chk("ab_req", {7'd0, local_request}, 8'h00);
        vme_as = 1'b1;
        cyc(2);
        chk("ab_req_lat2", {7'd0, local_request}, 8'h00);
        cyc(1);
        chk("ab_req_off", {7'd0, local_request}, 8'h01);
        chk("ab_dtack",   {7'd0, dtack_w},       8'h01);
        chk("ab_berr",    {7'd0, berr_w},        8'h01);
        bus_idle();
        cyc(4);

        // ack arrives in the very clock the counter reaches the timeout
        start_cycle(6'h39, 8'h20, 1'b1, 1'b0, 2'b00);
        cyc(3);
        chk("race_req", {7'd0, local_request}, 8'h00);
        cyc(13);
        local_ack = 1'b0;
        cyc(2);
        chk("race_dtack_early", {7'd0, dtack_w}, 8'h01);
        chk("race_berr_early",  {7'd0, berr_w},  8'h01);
        cyc(1);
        chk("race_dtack", {7'd0, dtack_w}, 8'h00);
        chk("race_berr",  {7'd0, berr_w},  8'h01);
        cyc(2);
        chk("race_berr_hold", {7'd0, berr_w}, 8'h01);
        bus_idle();
        cyc(4);

        // asynchronous reset while DTACK is asserted
        start_cycle(6'h3D, 8'h20, 1'b1, 1'b0, 2'b00);
        cyc(3);
        local_ack = 1'b0;
        cyc(3);
        chk("ar_dtack_before", {7'd0, dtack_w}, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_dtack", {7'd0, dtack_w},       8'h01);
        chk("ar_req",   {7'd0, local_request}, 8'h01);
        chk("ar_ds",    {6'd0, local_ds},      8'h03);
        bus_idle();
        cyc(1);
        reset = 1'b1;
        cyc(2);

        // normal decode after reset, then an address-pipelined second DS
        start_cycle(6'h39, 8'h20, 1'b0, 1'b1, 2'b01);
        cyc(2);
        chk("pr_req_lat2", {7'd0, local_request}, 8'h01);
        cyc(1);
        chk("pr_req",   {7'd0, local_request}, 8'h00);
        chk("pr_ds",    {6'd0, local_ds},      8'h01);
        chk("pr_lword", {7'd0, local_lword},   8'h01);
        chk("pr_write", {7'd0, local_write},   8'h00);
        local_ack = 1'b0;
        cyc(3);
        chk("pr_dtack", {7'd0, dtack_w}, 8'h00);
        vme_ds = 2'b11;
        local_ack = 1'b1;
        cyc(3);
        chk("pr_release_dtack", {7'd0, dtack_w},       8'h01);
        chk("pr_release_req",   {7'd0, local_request}, 8'h01);
        vme_ds = 2'b00;
        vme_lword = 1'b0;
        cyc(2);
        chk("pipe_req_lat2", {7'd0, local_request}, 8'h01);
        cyc(1);
        chk("pipe_req",   {7'd0, local_request}, 8'h00);
        chk("pipe_ds",    {6'd0, local_ds},      8'h00);
        chk("pipe_lword", {7'd0, local_lword},   8'h00);
        bus_idle();
        cyc(4);
        chk("end_req", {7'd0, local_request}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vme_slave_responder.md
VME_SLAVE_RESPONDER -- requirements
Module: vme_slave_responder

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be honoured as stated:
- TIMEOUT, 15, clocks waited for local_ack before bus error.
- AM_USER, 6'h39, accepted A24 user-data address modifier.
- AM_SUPER, 6'h3D, accepted A24 supervisor-data address modifier.
REQ-002 Ports (name, direction, width, meaning); the module SHALL provide exactly these:
- clock, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low.
- vme_as, in, 1, VME address strobe, active-low.
- vme_ds, in, 2, VME data strobes, active-low.
- vme_write, in, 1, VME write, active-low (0 = write).
- vme_lword, in, 1, VME long-word, active-low.
- vme_address_mod, in, 6, VME address modifier.
- vme_address_high, in, 8, VME A23..A16.
- base_address, in, 8, board base select (A23..A16).
- vme_dtack, out, 1, driven 0 when asserted, high-Z otherwise.
- vme_berr, out, 1, driven 0 when asserted, high-Z otherwise.
- local_request, out, 1, local access strobe, active-low.
- local_write, out, 1, local write, active-low.
- local_ds, out, 2, local byte-lane strobes, active-low.
- local_lword, out, 1, local 32-bit access, active-low.
- local_ack, in, 1, local access complete, active-low.

Function
REQ-003 vme_as, vme_ds and local_ack SHALL each pass a two-flop synchronizer; other inputs are sampled only while the synchronized strobes are stable.
REQ-004 A cycle SHALL match when: synchronized AS is low, synchronized DS != 2'b11, vme_address_mod is AM_USER or AM_SUPER, and vme_address_high == base_address.
REQ-005 States SHALL be IDLE, ACCESS, ACK, ERROR, RELEASE and IGNORE, encoded in a single state register.
REQ-006 IDLE: on a match, latch vme_write, vme_ds and vme_lword, clear the counter, go to ACCESS; if AS and DS are active but there is no match, go to IGNORE.
REQ-007 ACCESS: assert local_request with the latched write, ds and lword; increment the counter every clock.
- Synchronized local_ack low -> ACK.
- Counter == TIMEOUT -> ERROR.
- If both occur in the same clock, ACK SHALL win.
REQ-008 ACK: hold vme_dtack low and keep local_request asserted; when synchronized DS == 2'b11, go to RELEASE.
REQ-009 ERROR: hold vme_berr low and deassert local_request; when synchronized DS == 2'b11, go to RELEASE.
REQ-010 RELEASE: vme_dtack, vme_berr and local_request SHALL be inactive.
- Synchronized AS high -> IDLE.
- AS still low with a new DS low (address-pipelined cycle) -> re-evaluate REQ-004 next clock as if in IDLE.
REQ-011 IGNORE: drive nothing; go to IDLE when synchronized AS is high.
REQ-012 Master abort: synchronized AS high while in ACCESS, ACK or ERROR SHALL force IDLE next clock with all outputs inactive.
REQ-013 Latency:
- vme_ds pin low to local_request low: exactly 3 clocks.
- local_ack pin low to vme_dtack low: exactly 3 clocks.
- vme_dtack SHALL never be driven in the same clock as vme_berr.
REQ-014 The counter SHALL be wide enough for TIMEOUT, saturate at TIMEOUT, and never wrap.

Reset
REQ-015 While reset is low: state = IDLE, counter = 0, synchronizers = 1, local_request/local_write/local_lword = 1, local_ds = 2'b11, vme_dtack and vme_berr high-Z; this SHALL take effect asynchronously, including mid-cycle.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Read: AM=0x39, A23..16=base=0x20, ds=00, lword=0, local_ack after 2 clocks -> local_request low 3 clocks after ds, local_ds=00, local_lword=0, local_write=1; dtack low until ds released; then IDLE.
- Timeout: matched write, local_ack held high -> vme_berr low once 15 ACCESS clocks elapse, dtack never driven; release on ds=11.
- Non-match: AM=0x29 or address 0x21 with base 0x20 -> no local_request, dtack/berr high-Z for the whole cycle.
- Master abort: AS released during ACCESS -> local_request high and IDLE within 3 clocks of the AS pin edge.
- Race: local_ack sampled in the same clock the counter reaches TIMEOUT -> dtack asserted, berr stays high-Z.
- Async reset during ACK -> dtack high-Z and local_request high with no clock edge; next cycle decodes normally.
